window_gen_3x3: RTL

- Consumes the raster-order pixel stream that feeds the conv core and produces a 3x3 pixel window per accepted pixel once two full rows plus two pixels have arrived.
- Consumes delayed rows through two internal line delays and assembles the 9-pixel neighbourhood the 3x3 MAC array requires.
- Emits only "valid" convolution positions (no padding), tagged with output coordinates and an end-of-frame pulse.

---
 rtl/window_gen_3x3_pkg.sv | 16 +
 rtl/window_gen_3x3_if.sv | 26 ++
 rtl/window_gen_3x3_line_delay.sv | 35 +++
 rtl/window_gen_3x3.sv | 101 ++++++++++
 4 files changed

// File: rtl/window_gen_3x3_pkg.sv
// rtl/window_gen_3x3_pkg.sv - shared constants and helpers for the 3x3 window generator
package window_gen_3x3_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int WIN_DIM       = 3;

    // Flat element index of window position (r,c) inside o_window.
    function automatic int win_idx(input int r, input int c);
        return WIN_DIM * r + c;
    endfunction

    function automatic int coord_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// rtl/window_gen_3x3_if.sv - pixel-in / window-out bundle for the 3x3 window generator
interface window_gen_3x3_if
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int WIDTH      = DEFAULT_WIDTH
);
    logic                               i_valid;
    logic [WIDTH-1:0]                   i_data;
    logic                               o_valid;
    logic [9*WIDTH-1:0]                 o_window;
    logic [coord_w(IMG_WIDTH)-1:0]      o_col;
    logic [coord_w(IMG_HEIGHT)-1:0]     o_row;
    logic                               o_frame_done;

    modport master (
        output i_valid, i_data,
        input  o_valid, o_window, o_col, o_row, o_frame_done
    );

    modport slave (
        input  i_valid, i_data,
        output o_valid, o_window, o_col, o_row, o_frame_done
    );
endinterface

// File: rtl/window_gen_3x3_line_delay.sv
// rtl/window_gen_3x3_line_delay.sv - DEPTH-valid delay line: circular RAM plus registered output
module line_delay #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    // The output register supplies the last stage, so the RAM holds DEPTH-1 entries.
    localparam int ENTRIES = DEPTH - 1;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [AW-1:0]    ptr;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            ptr    <= '0;
            o_data <= '0;
        end else if (i_valid) begin
            o_data <= mem[ptr];
            ptr    <= (ptr == AW'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            mem[ptr] <= i_data;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster pixel stream to 3x3 neighbourhood windows, valid positions only
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int WIDTH      = DEFAULT_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    window_gen_3x3_if.slave   bus
);
    localparam int CW = coord_w(IMG_WIDTH);
    localparam int RW = coord_w(IMG_HEIGHT);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [WIDTH-1:0] dly_a;
    logic [WIDTH-1:0] dly_b;
    logic [WIDTH-1:0] win [3][3];
    logic             col_last;
    logic             row_last;

    assign col_last = (col == CW'(IMG_WIDTH - 1));
    assign row_last = (row == RW'(IMG_HEIGHT - 1));

    line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(WIDTH)) u_dly_a (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_valid  (bus.i_valid),
        .i_data   (bus.i_data),
        .o_data   (dly_a)
    );

    line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(WIDTH)) u_dly_b (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_valid  (bus.i_valid),
        .i_data   (dly_a),
        .o_data   (dly_b)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            col <= '0;
            row <= '0;
        end else if (bus.i_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Shift left; the newest column enters at c=2 with the oldest row at r=0.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (bus.i_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[2][2] <= bus.i_data;
            win[1][2] <= dly_a;
            win[0][2] <= dly_b;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            bus.o_valid      <= 1'b0;
            bus.o_col        <= '0;
            bus.o_row        <= '0;
            bus.o_frame_done <= 1'b0;
        end else begin
            bus.o_valid      <= bus.i_valid && (row >= RW'(2)) && (col >= CW'(2));
            bus.o_frame_done <= bus.i_valid && row_last && col_last;
            if (bus.i_valid) begin
                bus.o_col <= col - CW'(2);
                bus.o_row <= row - RW'(2);
            end
        end
    end

    always_comb begin
        bus.o_window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                bus.o_window[WIDTH*win_idx(r, c) +: WIDTH] = win[r][c];
            end
        end
    end

endmodule
